// File: rtl/switch_ingress_buffer.sv
// rtl/switch_ingress_buffer.sv - store-and-forward ingress buffer with header parse, filter and drop handling
// Accepts framed packets (start, DA, SA, LEN, payload), commits whole packets, forwards them FWFT.
module switch_ingress_buffer #(
   parameter int                DATA_W    = 8,
   parameter int                DEPTH     = 64,
   parameter int                FILTER_EN = 0,
   parameter logic [DATA_W-1:0] MY_ADDR   = '0,
   parameter int                CNT_W     = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              sw_enable_in,
   output logic              read_out,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic              err_trunc,
   output logic              err_oversize,
   output logic [CNT_W-1:0]  pkt_count,
   output logic [CNT_W-1:0]  drop_count
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DA   = 3'd1;
   localparam logic [2:0] S_SA   = 3'd2;
   localparam logic [2:0] S_LEN  = 3'd3;
   localparam logic [2:0] S_PAY  = 3'd4;
   localparam logic [2:0] S_DROP = 3'd5;
   localparam logic [2:0] S_WAIT = 3'd6;

   localparam logic [AW:0]       PTR_ONE = 1;
   localparam logic [AW:0]       IDX_TWO = 2;
   localparam logic [DATA_W-1:0] D_ONE   = 1;
   localparam logic [CNT_W-1:0]  C_ONE   = 1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + C_ONE;
   endfunction

   logic [2:0]        state;
   logic              prev_en;
   logic [AW:0]       wr_ptr;
   logic [AW:0]       commit_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W-1:0] remain;
   logic [AW:0]       rd_idx;
   logic [DATA_W-1:0] rd_len;
   logic [DATA_W-1:0] mem [DEPTH];

   logic full;
   logic in_hdr;
   logic beat;
   logic start;
   logic da_ok;
   logic too_big;
   logic wr_en;
   logic xfer;

   // Uncommitted words count against space too, so a packet in flight can fill the buffer.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_hdr  = state inside {S_DA, S_SA, S_LEN, S_PAY};
   assign read_out = in_hdr ? !full : 1'b1;
   assign beat    = sw_enable_in && read_out;
   assign start   = sw_enable_in && !prev_en;
   assign da_ok   = (FILTER_EN == 0) || (data_in == MY_ADDR) || (&data_in);
   assign too_big = (32'(data_in) + 32'd3) > 32'(DEPTH);

   always_comb begin
      wr_en = 1'b0;
      if (beat) begin
         case (state)
            S_DA:         wr_en = da_ok;
            S_SA, S_PAY:  wr_en = 1'b1;
            S_LEN:        wr_en = !too_big;
            default:      wr_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= data_in;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         prev_en      <= 1'b1;
         wr_ptr       <= '0;
         commit_ptr   <= '0;
         remain       <= '0;
         err_trunc    <= 1'b0;
         err_oversize <= 1'b0;
         pkt_count    <= '0;
         drop_count   <= '0;
      end else begin
         prev_en      <= sw_enable_in;
         err_trunc    <= 1'b0;
         err_oversize <= 1'b0;
         if (in_hdr && !sw_enable_in) begin
            wr_ptr     <= commit_ptr;
            err_trunc  <= 1'b1;
            drop_count <= sat_inc(drop_count);
            state      <= S_IDLE;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            case (state)
               S_IDLE: if (start) state <= S_DA;
               S_DA: if (beat) begin
                  if (da_ok) begin
                     state <= S_SA;
                  end else begin
                     drop_count <= sat_inc(drop_count);
                     state      <= S_DROP;
                  end
               end
               S_SA: if (beat) state <= S_LEN;
               S_LEN: if (beat) begin
                  if (too_big) begin
                     wr_ptr       <= commit_ptr;
                     err_oversize <= 1'b1;
                     drop_count   <= sat_inc(drop_count);
                     state        <= S_DROP;
                  end else if (data_in == '0) begin
                     commit_ptr <= wr_ptr + PTR_ONE;
                     pkt_count  <= sat_inc(pkt_count);
                     state      <= S_WAIT;
                  end else begin
                     remain <= data_in;
                     state  <= S_PAY;
                  end
               end
               S_PAY: if (beat) begin
                  if (remain == D_ONE) begin
                     commit_ptr <= wr_ptr + PTR_ONE;
                     pkt_count  <= sat_inc(pkt_count);
                     state      <= S_WAIT;
                  end else begin
                     remain <= remain - D_ONE;
                  end
               end
               S_DROP, S_WAIT: if (!sw_enable_in) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign out_valid = rd_ptr != commit_ptr;
   assign out_data  = mem[rd_ptr[AW-1:0]];
   assign out_sop   = out_valid && (rd_idx == '0);
   // At index 2 the LEN word is on out_data itself, later indices use the captured copy.
   assign out_eop   = out_valid && ((rd_idx == IDX_TWO) ? (out_data == '0)
                      : ((rd_idx > IDX_TWO) && (32'(rd_idx) == 32'(rd_len) + 32'd2)));
   assign xfer      = out_valid && out_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         rd_idx <= '0;
         rd_len <= '0;
      end else if (xfer) begin
         rd_ptr <= rd_ptr + PTR_ONE;
         rd_idx <= out_eop ? '0 : rd_idx + PTR_ONE;
         if (rd_idx == IDX_TWO) rd_len <= out_data;
      end
   end

endmodule

// File: tb/tb_switch_ingress_buffer.sv
// tb/tb_switch_ingress_buffer.sv - randomized bench with a packet-level reference model
module tb_switch_ingress_buffer;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       sw_en = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] din = 8'h00;

   logic        read_o [3];
   logic        valid_o [3];
   logic        sop_o [3];
   logic        eop_o [3];
   logic        etr_o [3];
   logic        eov_o [3];
   logic [7:0]  data_o [3];
   logic [15:0] pkt_o [2];
   logic [15:0] drop_o [2];
   logic [2:0]  pkt2, drop2;

   logic [1:0]  sel = 2'd0;
   logic        a_read, a_valid, a_sop, a_eop, a_etr, a_eov;
   logic [7:0]  a_data;
   logic [15:0] a_pkt, a_drop;

   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   logic [7:0] pl[$];
   int exp_pkt, exp_drop, exp_etr, exp_eov;
   int m_depth, m_cmax;
   bit m_filt;
   logic [7:0] m_addr;
   int gbase, etr_base, eov_base;
   int etr_cyc = 0;
   int eov_cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   assign a_read  = (sel == 2'd2) ? read_o[2]  : (sel == 2'd1) ? read_o[1]  : read_o[0];
   assign a_valid = (sel == 2'd2) ? valid_o[2] : (sel == 2'd1) ? valid_o[1] : valid_o[0];
   assign a_sop   = (sel == 2'd2) ? sop_o[2]   : (sel == 2'd1) ? sop_o[1]   : sop_o[0];
   assign a_eop   = (sel == 2'd2) ? eop_o[2]   : (sel == 2'd1) ? eop_o[1]   : eop_o[0];
   assign a_etr   = (sel == 2'd2) ? etr_o[2]   : (sel == 2'd1) ? etr_o[1]   : etr_o[0];
   assign a_eov   = (sel == 2'd2) ? eov_o[2]   : (sel == 2'd1) ? eov_o[1]   : eov_o[0];
   assign a_data  = (sel == 2'd2) ? data_o[2]  : (sel == 2'd1) ? data_o[1]  : data_o[0];
   assign a_pkt   = (sel == 2'd2) ? {13'd0, pkt2}  : (sel == 2'd1) ? pkt_o[1]  : pkt_o[0];
   assign a_drop  = (sel == 2'd2) ? {13'd0, drop2} : (sel == 2'd1) ? drop_o[1] : drop_o[0];

   switch_ingress_buffer u0 (
      .clock(clock), .reset_n(reset_n), .data_in(din), .sw_enable_in(sw_en),
      .read_out(read_o[0]), .out_data(data_o[0]), .out_valid(valid_o[0]), .out_ready(out_ready),
      .out_sop(sop_o[0]), .out_eop(eop_o[0]), .err_trunc(etr_o[0]), .err_oversize(eov_o[0]),
      .pkt_count(pkt_o[0]), .drop_count(drop_o[0]));

   switch_ingress_buffer #(.DEPTH(16), .FILTER_EN(1), .MY_ADDR(8'h07)) u1 (
      .clock(clock), .reset_n(reset_n), .data_in(din), .sw_enable_in(sw_en),
      .read_out(read_o[1]), .out_data(data_o[1]), .out_valid(valid_o[1]), .out_ready(out_ready),
      .out_sop(sop_o[1]), .out_eop(eop_o[1]), .err_trunc(etr_o[1]), .err_oversize(eov_o[1]),
      .pkt_count(pkt_o[1]), .drop_count(drop_o[1]));

   switch_ingress_buffer #(.DEPTH(8), .CNT_W(3)) u2 (
      .clock(clock), .reset_n(reset_n), .data_in(din), .sw_enable_in(sw_en),
      .read_out(read_o[2]), .out_data(data_o[2]), .out_valid(valid_o[2]), .out_ready(out_ready),
      .out_sop(sop_o[2]), .out_eop(eop_o[2]), .err_trunc(etr_o[2]), .err_oversize(eov_o[2]),
      .pkt_count(pkt2), .drop_count(drop2));

   always @(negedge clock) begin
      if (reset_n && a_valid && out_ready) got_q.push_back({a_sop, a_eop, a_data});
      if (a_etr) etr_cyc++;
      if (a_eov) eov_cyc++;
   end

   task automatic set_dut(input logic [1:0] s);
      sel     = s;
      m_depth = (s == 2'd0) ? 64 : (s == 2'd1) ? 16 : 8;
      m_filt  = (s == 2'd1);
      m_addr  = 8'h07;
      m_cmax  = (s == 2'd2) ? 7 : 65535;
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_pkt = 0; exp_drop = 0; exp_etr = 0; exp_eov = 0;
      gbase = got_q.size(); etr_base = etr_cyc; eov_base = eov_cyc;
   endtask

   task automatic do_reset(input logic [1:0] s);
      set_dut(s);
      reset_n = 1'b0; sw_en = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      clear_model();
   endtask

   task automatic gap();
      sw_en = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic beat(input logic [7:0] d);
      int n = 0;
      sw_en = 1'b1; din = d;
      @(negedge clock);
      while (a_read !== 1'b1 && n < 200) begin @(negedge clock); n++; end
      if (n >= 200) begin checks++; errors++; $display("FAIL beat_timeout read_out %b want 1", a_read); end
      @(posedge clock); #1;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      @(negedge clock);
      while (a_valid === 1'b1 && n < 300) begin @(negedge clock); n++; end
      checks++;
      if (n >= 300) begin errors++; $display("FAIL drain_timeout out_valid %b want 0", a_valid); end
      @(posedge clock); #1;
   endtask

   task automatic fill(input int n);
      pl.delete();
      repeat (n) pl.push_back(8'($urandom));
   endtask

   // Packet-level outcome: dropped by truncation, address filter or size, else forwarded whole.
   task automatic model_pkt(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len, input bit trunc);
      if (trunc) begin exp_drop++; exp_etr++; end
      else if (m_filt && da != m_addr && da != 8'hff) exp_drop++;
      else if (int'(len) + 3 > m_depth) begin exp_drop++; exp_eov++; end
      else begin
         exp_pkt++;
         exp_q.push_back({2'b10, da});
         exp_q.push_back({2'b00, sa});
         exp_q.push_back({1'b0, len == 8'd0, len});
         for (int i = 0; i < int'(len); i++) exp_q.push_back({1'b0, i == int'(len) - 1, pl[i]});
      end
   endtask

   task automatic send_pkt(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len, input int trunc_at);
      gap();
      beat(8'($urandom));
      beat(da); beat(sa); beat(len);
      for (int i = 0; i < int'(len); i++) begin
         if (i == trunc_at) break;
         beat(pl[i]);
      end
      model_pkt(da, sa, len, trunc_at >= 0);
   endtask

   task automatic check_egress_and_counts(input string tag);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sw_en = 1'b1; din = 8'h5a;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({read_o[i], valid_o[i], sop_o[i], eop_o[i], etr_o[i], eov_o[i]} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outs dut%0d got %b want 100000", i,
                     {read_o[i], valid_o[i], sop_o[i], eop_o[i], etr_o[i], eov_o[i]});
         end
      end
      checks++;
      if ({pkt_o[0], drop_o[0], pkt_o[1], drop_o[1], pkt2, drop2} !== 70'd0) begin
         errors++; $display("FAIL reset_counts got %h want 0", {pkt_o[0], drop_o[0], pkt_o[1], drop_o[1], pkt2, drop2});
      end
   endtask

   task automatic test_basic();
      do_reset(2'd0);
      pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
      send_pkt(8'h05, 8'h0a, 8'd3, -1);
      gap(); drain();
      checks++;
      if (got_q.size() - gbase != 6) begin errors++; $display("FAIL basic_nwords got %0d want 6", got_q.size() - gbase); end
      foreach (exp_q[i]) if (gbase + i < got_q.size()) begin
         checks++;
         if (got_q[gbase + i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, got_q[gbase + i], exp_q[i]); end
      end
      checks++;
      if (a_pkt !== 16'd1) begin errors++; $display("FAIL basic_pkt_count got %0d want 1", a_pkt); end
   endtask

   task automatic test_len0_back_to_back();
      do_reset(2'd0);
      fill(0); send_pkt(8'h05, 8'h0a, 8'd0, -1);
      fill(2); send_pkt(8'h06, 8'h0b, 8'd2, -1);
      gap(); drain();
      checks++;
      if (got_q.size() - gbase != exp_q.size()) begin errors++; $display("FAIL len0_nwords got %0d want %0d", got_q.size() - gbase, exp_q.size()); end
      foreach (exp_q[i]) if (gbase + i < got_q.size()) begin
         checks++;
         if (got_q[gbase + i] !== exp_q[i]) begin errors++; $display("FAIL len0_word%0d got %h want %h", i, got_q[gbase + i], exp_q[i]); end
      end
      checks++;
      if (a_pkt !== 16'd2) begin errors++; $display("FAIL len0_pkt_count got %0d want 2", a_pkt); end
   endtask

   task automatic test_trunc();
      do_reset(2'd0);
      fill(5); send_pkt(8'h21, 8'h22, 8'd5, 2);
      gap();
      fill(4); send_pkt(8'h31, 8'h32, 8'd4, -1);
      gap(); drain();
      checks++;
      if (got_q.size() - gbase != exp_q.size()) begin errors++; $display("FAIL trunc_nwords got %0d want %0d", got_q.size() - gbase, exp_q.size()); end
      foreach (exp_q[i]) if (gbase + i < got_q.size()) begin
         checks++;
         if (got_q[gbase + i] !== exp_q[i]) begin errors++; $display("FAIL trunc_word%0d got %h want %h", i, got_q[gbase + i], exp_q[i]); end
      end
      checks++;
      if (etr_cyc - etr_base != exp_etr) begin errors++; $display("FAIL trunc_pulse_cycles got %0d want %0d", etr_cyc - etr_base, exp_etr); end
      checks++;
      if (int'(a_drop) != exp_drop || int'(a_pkt) != exp_pkt) begin
         errors++; $display("FAIL trunc_counts got %0d/%0d want %0d/%0d", a_pkt, a_drop, exp_pkt, exp_drop);
      end
   endtask

   task automatic test_oversize_filter();
      do_reset(2'd1);
      fill(14); send_pkt(8'h07, 8'h01, 8'd14, -1);
      fill(3);  send_pkt(8'h09, 8'h02, 8'd3, -1);
      fill(2);  send_pkt(8'hff, 8'h03, 8'd2, -1);
      fill(13); send_pkt(8'h07, 8'h04, 8'd13, -1);
      gap(); drain();
      checks++;
      if (got_q.size() - gbase != exp_q.size()) begin errors++; $display("FAIL ovf_nwords got %0d want %0d", got_q.size() - gbase, exp_q.size()); end
      foreach (exp_q[i]) if (gbase + i < got_q.size()) begin
         checks++;
         if (got_q[gbase + i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d got %h want %h", i, got_q[gbase + i], exp_q[i]); end
      end
      checks++;
      if (eov_cyc - eov_base != exp_eov || etr_cyc - etr_base != exp_etr) begin
         errors++; $display("FAIL ovf_pulses got %0d/%0d want %0d/%0d", eov_cyc - eov_base, etr_cyc - etr_base, exp_eov, exp_etr);
      end
      checks++;
      if (int'(a_drop) != exp_drop || int'(a_pkt) != exp_pkt) begin
         errors++; $display("FAIL ovf_counts got %0d/%0d want %0d/%0d", a_pkt, a_drop, exp_pkt, exp_drop);
      end
   endtask

   task automatic test_stall();
      do_reset(2'd2);
      out_ready = 1'b0;
      fill(2); send_pkt(8'h01, 8'h02, 8'd2, -1);
      gap();
      beat(8'h00); beat(8'h03); beat(8'h04); beat(8'h02);
      fill(2);
      sw_en = 1'b1; din = pl[0];
      repeat (4) begin
         @(negedge clock);
         checks++;
         if (a_read !== 1'b0) begin errors++; $display("FAIL stall_read_out got %b want 0", a_read); end
      end
      checks++;
      if ({a_valid, a_sop, a_data} !== 10'b11_0000_0001) begin
         errors++; $display("FAIL stall_head got %b want 1100000001", {a_valid, a_sop, a_data});
      end
      @(posedge clock); #1;
      out_ready = 1'b1;
      beat(pl[0]); beat(pl[1]);
      model_pkt(8'h03, 8'h04, 8'd2, 1'b0);
      gap(); drain();
      checks++;
      if (got_q.size() - gbase != exp_q.size()) begin errors++; $display("FAIL stall_nwords got %0d want %0d", got_q.size() - gbase, exp_q.size()); end
      foreach (exp_q[i]) if (gbase + i < got_q.size()) begin
         checks++;
         if (got_q[gbase + i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d got %h want %h", i, got_q[gbase + i], exp_q[i]); end
      end
      checks++;
      if (a_pkt !== 16'd2) begin errors++; $display("FAIL stall_pkt_count got %0d want 2", a_pkt); end
   endtask

   task automatic test_random(input logic [1:0] s, input int npk);
      bit done;
      do_reset(s);
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < npk; k++) begin
               int len, tr;
               len = $urandom_range(0, 9);
               if ($urandom_range(0, 5) == 0) len = $urandom_range(m_depth - 4, m_depth + 1);
               tr = -1;
               if (len > 0 && len + 3 <= m_depth && $urandom_range(0, 5) == 0) tr = $urandom_range(0, len - 1);
               fill(len);
               send_pkt(8'($urandom), 8'($urandom), 8'(len), tr);
            end
            gap();
            done = 1'b1;
         end
         begin
            while (!done) begin @(posedge clock); #1; out_ready = 1'($urandom); end
         end
      join
      drain();
      checks++;
      if (got_q.size() - gbase != exp_q.size()) begin errors++; $display("FAIL rand%0d_nwords got %0d want %0d", s, got_q.size() - gbase, exp_q.size()); end
      foreach (exp_q[i]) if (gbase + i < got_q.size()) begin
         checks++;
         if (got_q[gbase + i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d got %h want %h", s, i, got_q[gbase + i], exp_q[i]); end
      end
      checks++;
      if (int'(a_pkt) != ((exp_pkt > m_cmax) ? m_cmax : exp_pkt)) begin
         errors++; $display("FAIL rand%0d_pkt_count got %0d want %0d", s, a_pkt, (exp_pkt > m_cmax) ? m_cmax : exp_pkt);
      end
      checks++;
      if (int'(a_drop) != ((exp_drop > m_cmax) ? m_cmax : exp_drop)) begin
         errors++; $display("FAIL rand%0d_drop_count got %0d want %0d", s, a_drop, (exp_drop > m_cmax) ? m_cmax : exp_drop);
      end
      checks++;
      if (etr_cyc - etr_base != exp_etr || eov_cyc - eov_base != exp_eov) begin
         errors++; $display("FAIL rand%0d_pulses got %0d/%0d want %0d/%0d", s, etr_cyc - etr_base, eov_cyc - eov_base, exp_etr, exp_eov);
      end
   endtask

   task automatic test_reset_midpacket();
      do_reset(2'd0);
      gap();
      beat(8'h00); beat(8'h05); beat(8'h0a); beat(8'h06); beat(8'haa); beat(8'hbb);
      reset_n = 1'b0;
      @(negedge clock);
      checks++;
      if ({a_read, a_valid, a_sop, a_eop, a_etr, a_eov} !== 6'b100000 || a_pkt !== 16'd0 || a_drop !== 16'd0) begin
         errors++; $display("FAIL midrst_outs got %b/%0d/%0d want 100000/0/0", {a_read, a_valid, a_sop, a_eop, a_etr, a_eov}, a_pkt, a_drop);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      clear_model();
      repeat (4) beat(8'($urandom));
      @(negedge clock);
      checks++;
      if (a_valid !== 1'b0) begin errors++; $display("FAIL midrst_ignored out_valid got %b want 0", a_valid); end
      @(posedge clock); #1;
      fill(3); send_pkt(8'h12, 8'h34, 8'd3, -1);
      gap(); drain();
      checks++;
      if (got_q.size() - gbase != exp_q.size()) begin errors++; $display("FAIL midrst_nwords got %0d want %0d", got_q.size() - gbase, exp_q.size()); end
      foreach (exp_q[i]) if (gbase + i < got_q.size()) begin
         checks++;
         if (got_q[gbase + i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word%0d got %h want %h", i, got_q[gbase + i], exp_q[i]); end
      end
      checks++;
      if (a_pkt !== 16'd1 || a_drop !== 16'd0) begin errors++; $display("FAIL midrst_counts got %0d/%0d want 1/0", a_pkt, a_drop); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len0_back_to_back();
      test_trunc();
      test_oversize_filter();
      test_stall();
      test_reset_midpacket();
      test_random(2'd0, 30);
      test_random(2'd2, 24);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
